mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters.
//  - Requester A: pipeline MEM stage.
//  - Requester B: debug unit, which reads and writes data memory over UART.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_mux2to1.sv | 15 +
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Encodings and the idle-state owner pick shared by the data-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWN_A = 2'd1;
   localparam logic [1:0] ST_OWN_B = 2'd2;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // A lone requester wins; a tie goes to whoever was not served last.
   function automatic logic [1:0] pick_owner(input logic req_a,
                                             input logic req_b,
                                             input logic last_served);
      logic [1:0] st;
      if (req_a && req_b) begin
         st = (last_served == SEL_A) ? ST_OWN_B : ST_OWN_A;
      end else if (req_a) begin
         st = ST_OWN_A;
      end else if (req_b) begin
         st = ST_OWN_B;
      end else begin
         st = ST_IDLE;
      end
      return st;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2to1.sv
// Two-input command mux; select encoding follows the arbiter owner select.
module mem_port_arbiter_mux2to1
   import mem_port_arbiter_pkg::*;
#(
   parameter int NB = 1
) (
   input  logic [NB-1:0] i_d0,
   input  logic [NB-1:0] i_d1,
   input  logic          i_sel,
   output logic [NB-1:0] o_y
);

   assign o_y = (i_sel == SEL_B) ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the data-memory port shared by the MEM stage (A) and the debug unit (B),
// with a burst cap so a busy owner cannot starve the other side.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NB_DATA   = 32,
   parameter int NB_ADDR   = 10,
   parameter int MAX_BURST = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_a,
   input  logic               i_we_a,
   input  logic [NB_ADDR-1:0] i_addr_a,
   input  logic [NB_DATA-1:0] i_wdata_a,
   input  logic               i_req_b,
   input  logic               i_we_b,
   input  logic [NB_ADDR-1:0] i_addr_b,
   input  logic [NB_DATA-1:0] i_wdata_b,
   output logic               o_gnt_a,
   output logic               o_gnt_b,
   output logic               o_rvalid_a,
   output logic               o_rvalid_b,
   output logic [NB_DATA-1:0] o_rdata,
   output logic               o_sel,
   output logic               o_mem_en,
   output logic               o_mem_we,
   output logic [NB_ADDR-1:0] o_mem_addr,
   output logic [NB_DATA-1:0] o_mem_wdata,
   input  logic [NB_DATA-1:0] i_mem_rdata
);

   localparam int NB_CNT = $clog2(MAX_BURST + 1);
   localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(MAX_BURST);
   localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_q, last_d;
   logic [NB_CNT-1:0] burst_q, burst_d, burst_inc;
   logic              rvalid_a_q, rvalid_b_q;
   logic              gnt_a, gnt_b, issue;
   logic              we_mux;

   assign gnt_a     = (state_q == ST_OWN_A) && i_req_a;
   assign gnt_b     = (state_q == ST_OWN_B) && i_req_b;
   assign issue     = gnt_a || gnt_b;
   assign burst_inc = (burst_q == CNT_MAX) ? burst_q : burst_q + CNT_ONE;

   // Ownership transitions; a burst-capped owner hands over with no dead cycle.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            state_d = pick_owner(i_req_a, i_req_b, last_q);
         end
         ST_OWN_A: begin
            if (gnt_a) begin
               last_d = SEL_A;
               if ((burst_inc == CNT_MAX) && i_req_b) begin
                  state_d = ST_OWN_B;
               end else begin
                  state_d = ST_OWN_A;
               end
            end else begin
               state_d = i_req_b ? ST_OWN_B : ST_IDLE;
            end
         end
         ST_OWN_B: begin
            if (gnt_b) begin
               last_d = SEL_B;
               if ((burst_inc == CNT_MAX) && i_req_a) begin
                  state_d = ST_OWN_A;
               end else begin
                  state_d = ST_OWN_B;
               end
            end else begin
               state_d = i_req_a ? ST_OWN_A : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Burst count restarts on every ownership change; select follows the new owner, held in IDLE.
   always_comb begin
      if (state_d != state_q) begin
         burst_d = '0;
      end else if (issue) begin
         burst_d = burst_inc;
      end else begin
         burst_d = burst_q;
      end
      if (state_d == ST_OWN_A) begin
         sel_d = SEL_A;
      end else if (state_d == ST_OWN_B) begin
         sel_d = SEL_B;
      end else begin
         sel_d = sel_q;
      end
   end

   // State, counter and read-return registers; reset drops any read in flight.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= SEL_A;
         last_q     <= SEL_B;
         burst_q    <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         burst_q    <= burst_d;
         rvalid_a_q <= gnt_a && !i_we_a;
         rvalid_b_q <= gnt_b && !i_we_b;
      end
   end

   mem_port_arbiter_mux2to1 #(.NB(NB_ADDR)) u_mux_addr (
      .i_d0 (i_addr_a),
      .i_d1 (i_addr_b),
      .i_sel(sel_q),
      .o_y  (o_mem_addr)
   );

   mem_port_arbiter_mux2to1 #(.NB(NB_DATA)) u_mux_wdata (
      .i_d0 (i_wdata_a),
      .i_d1 (i_wdata_b),
      .i_sel(sel_q),
      .o_y  (o_mem_wdata)
   );

   mem_port_arbiter_mux2to1 #(.NB(1)) u_mux_we (
      .i_d0 (i_we_a),
      .i_d1 (i_we_b),
      .i_sel(sel_q),
      .o_y  (we_mux)
   );

   assign o_gnt_a    = gnt_a;
   assign o_gnt_b    = gnt_b;
   assign o_rvalid_a = rvalid_a_q;
   assign o_rvalid_b = rvalid_b_q;
   assign o_rdata    = i_mem_rdata;
   assign o_sel      = sel_q;
   assign o_mem_en   = issue;
   assign o_mem_we   = issue && we_mux;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural
// ownership model and a shadow memory, all compared every cycle.
module tb_mem_port_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [1:0]  we  = 2'b00;
   logic [9:0]  addr [2];
   logic [31:0] wd   [2];

   logic        o_gnt_a, o_gnt_b, o_rvalid_a, o_rvalid_b, o_sel, o_mem_en, o_mem_we;
   logic [31:0] o_rdata, o_mem_wdata, mem_rdata;
   logic [9:0]  o_mem_addr;

   logic [31:0] mem    [1024];
   logic [31:0] shadow [1024];
   logic        mem_init = 1'b0;
   logic        sh_init  = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model: owner -1 none / 0 A / 1 B, run = accesses since ownership began
   int          m_own, m_run, m_last, o, x;
   logic        m_sel;
   logic [1:0]  eg, last_gnt, pend_v;
   logic [31:0] pend_d [2];
   int          wait_c [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.NB_DATA(32), .NB_ADDR(10), .MAX_BURST(MAXB)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_req_a(req[0]), .i_we_a(we[0]), .i_addr_a(addr[0]), .i_wdata_a(wd[0]),
      .i_req_b(req[1]), .i_we_b(we[1]), .i_addr_b(addr[1]), .i_wdata_b(wd[1]),
      .o_gnt_a(o_gnt_a), .o_gnt_b(o_gnt_b), .o_rvalid_a(o_rvalid_a), .o_rvalid_b(o_rvalid_b),
      .o_rdata(o_rdata), .o_sel(o_sel), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] pat(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'hA500_0000 ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // synchronous-read data memory with one cycle of read latency
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
         mem_init <= 1'b1;
      end else if (o_mem_en) begin
         if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
         else          mem_rdata       <= mem[o_mem_addr];
      end
   end

   // compare process: check outputs against the model mid-cycle, then advance the model
   initial forever begin
      @(negedge clk);
      if (!sh_init) begin
         for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
         sh_init = 1'b1;
      end
      if (rst) begin
         m_own = -1; m_run = 0; m_last = 1; m_sel = 1'b0;
         pend_v = 2'b00; last_gnt = 2'b00; wait_c[0] = 0; wait_c[1] = 0;
         chk("rst_gnt",    {62'd0, o_gnt_a, o_gnt_b},       64'd0);
         chk("rst_rvalid", {62'd0, o_rvalid_a, o_rvalid_b}, 64'd0);
         chk("rst_mem",    {62'd0, o_mem_en, o_mem_we},     64'd0);
         chk("rst_sel",    {63'd0, o_sel},                  64'd0);
      end else begin
         for (int p = 0; p < 2; p++) eg[p] = (m_own == p) && req[p];
         chk("gnt_a",    {63'd0, o_gnt_a}, {63'd0, eg[0]});
         chk("gnt_b",    {63'd0, o_gnt_b}, {63'd0, eg[1]});
         chk("one_gnt",  {63'd0, o_gnt_a & o_gnt_b}, 64'd0);
         chk("sel",      {63'd0, o_sel}, {63'd0, m_sel});
         chk("mem_en",   {63'd0, o_mem_en}, {63'd0, eg[0] | eg[1]});
         chk("mem_we",   {63'd0, o_mem_we}, {63'd0, (eg[0] & we[0]) | (eg[1] & we[1])});
         chk("rvalid_a", {63'd0, o_rvalid_a}, {63'd0, pend_v[0]});
         chk("rvalid_b", {63'd0, o_rvalid_b}, {63'd0, pend_v[1]});
         for (int p = 0; p < 2; p++) begin
            if (pend_v[p]) chk("rdata", {32'd0, o_rdata}, {32'd0, pend_d[p]});
            if (eg[p]) begin
               chk("mem_addr", {54'd0, o_mem_addr}, {54'd0, addr[p]});
               if (we[p]) chk("mem_wdata", {32'd0, o_mem_wdata}, {32'd0, wd[p]});
               chk("wait_bound", {63'd0, wait_c[p] <= MAXB + 1}, 64'd1);
            end
         end
         for (int p = 0; p < 2; p++) begin
            pend_v[p] = eg[p] && !we[p];
            pend_d[p] = shadow[addr[p]];
            if (eg[p] && we[p]) shadow[addr[p]] = wd[p];
            if (req[p] && !eg[p]) wait_c[p]++;
            else                  wait_c[p] = 0;
         end
         if (m_own < 0) begin
            if (req[0] && req[1]) m_own = 1 - m_last;
            else if (req[0])      m_own = 0;
            else if (req[1])      m_own = 1;
            m_run = 0;
         end else begin
            o = m_own;
            x = 1 - m_own;
            if (req[o]) begin
               m_last = o;
               if (m_run < MAXB) m_run++;
               if (m_run == MAXB && req[x]) begin
                  m_own = x;
                  m_run = 0;
               end
            end else begin
               m_own = req[x] ? x : -1;
               m_run = 0;
            end
         end
         if (m_own >= 0) m_sel = m_own[0];
         last_gnt = eg;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      req = 2'b00;
      we  = 2'b00;
      step();
      rst = 1'b0;
   endtask

   initial begin
      addr[0] = 10'd0; addr[1] = 10'd0; wd[0] = 32'd0; wd[1] = 32'd0;
      repeat (2) step();

      // A alone reads 0x010
      do_reset();
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h010;
      @(negedge clk); chk("t2_no_gnt_idle", {63'd0, o_gnt_a}, 64'd0);
      step();
      @(negedge clk); chk("t2_gnt_a", {63'd0, o_gnt_a}, 64'd1);
      chk("t2_addr", {54'd0, o_mem_addr}, 64'h010);
      step(); req[0] = 1'b0;
      @(negedge clk); chk("t2_rvalid_a", {63'd0, o_rvalid_a}, 64'd1);
      chk("t2_rdata", {32'd0, o_rdata}, 64'hDEADBEEF);

      // both request from reset: four A accesses, then B with no dead cycle
      do_reset();
      req = 2'b11; we = 2'b00; addr[0] = 10'h020; addr[1] = 10'h021;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         step();
         @(negedge clk); chk("t3_gnt_a", {62'd0, o_gnt_a, o_gnt_b}, 64'd2);
      end
      step();
      @(negedge clk); chk("t3_gnt_b", {62'd0, o_gnt_a, o_gnt_b}, 64'd1);
      chk("t3_sel", {63'd0, o_sel}, 64'd1);
      chk("t3_rvalid_a_overlap", {63'd0, o_rvalid_a}, 64'd1);

      // B writes alone: continuous grants past the burst cap
      do_reset();
      req = 2'b10; we = 2'b10; addr[1] = 10'h3FF; wd[1] = 32'h0000CAFE;
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         step();
         @(negedge clk); chk("t4_gnt_b", {63'd0, o_gnt_b}, 64'd1);
         chk("t4_we", {63'd0, o_mem_we}, 64'd1);
         chk("t4_sel", {63'd0, o_sel}, 64'd1);
         chk("t4_no_rvalid", {63'd0, o_rvalid_b}, 64'd0);
      end
      step(); req = 2'b00;
      @(negedge clk); chk("t4_no_rvalid_end", {63'd0, o_rvalid_b}, 64'd0);
      chk("t4_sel_held", {63'd0, o_sel}, 64'd1);
      chk("t4_mem", {32'd0, mem[10'h3FF]}, 64'h0000CAFE);

      // A reads then drops while B writes
      do_reset();
      req = 2'b11; we = 2'b10; addr[0] = 10'h004; addr[1] = 10'h005; wd[1] = 32'h1234_5678;
      @(negedge clk);
      step();
      @(negedge clk); chk("t5_gnt_a", {63'd0, o_gnt_a}, 64'd1);
      step(); req[0] = 1'b0;
      @(negedge clk); chk("t5_gap", {62'd0, o_gnt_a, o_gnt_b}, 64'd0);
      chk("t5_rvalid_a", {63'd0, o_rvalid_a}, 64'd1);
      step();
      @(negedge clk); chk("t5_gnt_b", {63'd0, o_gnt_b}, 64'd1);
      step();
      @(negedge clk); chk("t5_no_rvalid_b", {63'd0, o_rvalid_b}, 64'd0);
      step(); req = 2'b00;
      @(negedge clk); chk("t5_no_rvalid_b2", {63'd0, o_rvalid_b}, 64'd0);

      // reset asserted mid-burst while A reads
      do_reset();
      req = 2'b01; we = 2'b00; addr[0] = 10'h030;
      step(); step();
      @(negedge clk); chk("t1_pre_gnt", {63'd0, o_gnt_a}, 64'd1);
      step(); rst = 1'b1;
      @(negedge clk); chk("t1_gnt", {62'd0, o_gnt_a, o_gnt_b}, 64'd0);
      chk("t1_rvalid", {62'd0, o_rvalid_a, o_rvalid_b}, 64'd0);
      chk("t1_mem", {62'd0, o_mem_en, o_mem_we}, 64'd0);
      chk("t1_sel", {63'd0, o_sel}, 64'd0);
      step(); rst = 1'b0; req = 2'b00;
      @(negedge clk); chk("t1_no_rvalid_after", {63'd0, o_rvalid_a}, 64'd0);

      // randomized traffic; requests are held until granted, occasionally abandoned
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         step();
         for (int p = 0; p < 2; p++) begin
            if (req[p] && !last_gnt[p]) begin
               if ($urandom_range(0, 99) < 3) req[p] = 1'b0;
            end else begin
               req[p]  = ($urandom_range(0, 99) < 55);
               we[p]   = 1'($urandom_range(0, 1));
               addr[p] = 10'($urandom_range(0, 31));
               wd[p]   = $urandom;
            end
         end
      end
      step(); req = 2'b00;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
